// File: rtl/ppi_pkg.sv
// ppi_pkg: shared state types, bus addresses and decode helpers for the Port A Mode 1 sequencer.
package ppi_pkg;
  typedef enum logic [1:0] {IN_IDLE, IN_EMPTY, IN_FULL, IN_READ} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_EMPTY, OUT_FULL, OUT_ACK} out_state_e;
  localparam logic [1:0] ADDR_PA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd3;
  localparam logic [2:0] INTE_A_IN_BIT = 3'd4;
  localparam logic [2:0] INTE_A_OUT_BIT = 3'd6;
  function automatic logic is_mode1(input logic [7:0] cw);
    return cw[7] && cw[6:5] == 2'b01;
  endfunction
  function automatic logic bsr_hits_inte(input logic [7:0] data, input logic dir_in);
    return data[3:1] == (dir_in ? INTE_A_IN_BIT : INTE_A_OUT_BIT);
  endfunction
endpackage

// File: rtl/ppi_sync_edge.sv
// ppi_sync_edge: optional synchronizer chain followed by registered one-cycle rise/fall pulses.
// STAGES=0 bypasses the chain for signals that are already clock-synchronous.
module ppi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_fall,
  output logic o_rise
);
  logic w_s;
  logic r_d, r_fall, r_rise;
  if (STAGES == 0) begin : g_direct
    assign w_s = i_d;
  end else begin : g_sync
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_sync <= '1;
      else begin
        r_sync[0] <= i_d;
        for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    assign w_s = r_sync[STAGES-1];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_d    <= 1'b1;
      r_fall <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_d    <= w_s;
      r_fall <= r_d & ~w_s;
      r_rise <= ~r_d & w_s;
    end
  assign o_fall = r_fall;
  assign o_rise = r_rise;
endmodule

// File: rtl/ppi_porta_mode1_ctrl.sv
// ppi_porta_mode1_ctrl: 8255 group-A Mode 1 strobed handshake for Port A.
// Owns INTE_A, the Port A input latch and the IBF/OBF_N/INTR handshake lines.
module ppi_porta_mode1_ctrl
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_control_word,
  input  logic [1:0] i_a,
  input  logic       i_read,
  input  logic       i_write,
  input  logic [7:0] i_data,
  input  logic [7:0] i_pa_in,
  input  logic       i_stb_n,
  input  logic       i_ack_n,
  output logic [7:0] o_pa_latch,
  output logic       o_ibf,
  output logic       o_obf_n,
  output logic       o_intr,
  output logic       o_inte
);
  in_state_e  r_in_st, w_in_nxt;
  out_state_e r_out_st, w_out_nxt;
  logic       r_flag, w_flag_nxt, r_inte, w_inte_nxt, r_intr;
  logic [7:0] r_latch, w_latch_nxt;
  logic       w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise;
  logic       w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic       w_dir_in, w_ctrl_wr, w_mode_set, w_bsr_inte;
  logic       w_pa_rd_fall, w_pa_rd_rise, w_pa_wr_fall, w_pa_wr_rise;
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_stb_n), .o_fall(w_stb_fall), .o_rise(w_stb_rise));
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_ack_n), .o_fall(w_ack_fall), .o_rise(w_ack_rise));
  ppi_sync_edge #(.STAGES(0)) u_rd (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_read), .o_fall(w_rd_fall), .o_rise(w_rd_rise));
  ppi_sync_edge #(.STAGES(0)) u_wr (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_write), .o_fall(w_wr_fall), .o_rise(w_wr_rise));
  assign w_dir_in     = i_control_word[4];
  assign w_ctrl_wr    = w_wr_rise && i_a == ADDR_CTRL;
  assign w_mode_set   = w_ctrl_wr && i_data[7];
  assign w_bsr_inte   = w_ctrl_wr && !i_data[7] && bsr_hits_inte(i_data, w_dir_in);
  assign w_pa_rd_fall = w_rd_fall && i_a == ADDR_PA;
  assign w_pa_rd_rise = w_rd_rise && i_a == ADDR_PA;
  assign w_pa_wr_fall = w_wr_fall && i_a == ADDR_PA;
  assign w_pa_wr_rise = w_wr_rise && i_a == ADDR_PA;
  always_comb begin
    w_in_nxt    = r_in_st;
    w_out_nxt   = r_out_st;
    w_flag_nxt  = r_flag;
    w_inte_nxt  = w_bsr_inte ? i_data[0] : r_inte;
    w_latch_nxt = r_latch;
    if (w_mode_set || !is_mode1(i_control_word)) begin
      w_in_nxt   = IN_IDLE;
      w_out_nxt  = OUT_IDLE;
      w_flag_nxt = 1'b0;
      if (w_mode_set) w_inte_nxt = 1'b0;
    end else if (w_dir_in) begin
      w_out_nxt = OUT_IDLE;
      // a direction swap spends one cycle with both machines idle
      if (r_out_st != OUT_IDLE) w_flag_nxt = 1'b0;
      else case (r_in_st)
        IN_IDLE:  w_in_nxt = IN_EMPTY;
        IN_EMPTY: if (w_stb_fall) begin
          w_latch_nxt = i_pa_in;
          w_in_nxt    = IN_FULL;
        end
        IN_FULL: begin
          if (w_stb_rise) w_flag_nxt = r_inte;
          if (w_pa_rd_fall) begin
            w_flag_nxt = 1'b0;
            w_in_nxt   = IN_READ;
          end
        end
        default: if (w_pa_rd_rise) w_in_nxt = IN_EMPTY;
      endcase
    end else begin
      w_in_nxt = IN_IDLE;
      if (r_in_st != IN_IDLE) w_flag_nxt = 1'b0;
      else if (r_out_st == OUT_IDLE) w_out_nxt = OUT_EMPTY;
      else begin
        if (w_pa_wr_fall) w_flag_nxt = 1'b0;
        if (w_pa_wr_rise) w_out_nxt = OUT_FULL;
        else if (r_out_st == OUT_FULL && w_ack_fall) w_out_nxt = OUT_ACK;
        else if (r_out_st == OUT_ACK && w_ack_rise) begin
          w_flag_nxt = r_inte;
          w_out_nxt  = OUT_EMPTY;
        end
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_in_st  <= IN_IDLE;
      r_out_st <= OUT_IDLE;
      r_flag   <= 1'b0;
      r_inte   <= 1'b0;
      r_intr   <= 1'b0;
      r_latch  <= '0;
    end else begin
      r_in_st  <= w_in_nxt;
      r_out_st <= w_out_nxt;
      r_flag   <= w_flag_nxt;
      r_inte   <= w_inte_nxt;
      r_intr   <= r_flag & r_inte;
      r_latch  <= w_latch_nxt;
    end
  assign o_pa_latch = r_latch;
  assign o_ibf      = r_in_st == IN_FULL || r_in_st == IN_READ;
  assign o_obf_n    = r_out_st != OUT_FULL;
  assign o_intr     = r_intr;
  assign o_inte     = r_inte;
endmodule
